// File: rtl/counting_pkg.sv
// ---------------------------------------------------------------------------
// counting_pkg
// Shared constants for the 2-bit symbol counting datapath. The symbol
// constants are common to the sequence generator and its paired detector;
// the state encoding and helpers belong to the generator.
// No ports (package).
// ---------------------------------------------------------------------------
package counting_pkg;

  // Symbol alphabet carried on num[1:0]
  localparam logic [1:0] SYM_IDLE = 2'b00;
  localparam logic [1:0] SYM_HEAD = 2'b01;
  localparam logic [1:0] SYM_MID  = 2'b10;
  localparam logic [1:0] SYM_END  = 2'b11;

  // Generator state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HEAD = 3'd1;
  localparam logic [2:0] ST_RUN2 = 3'd2;
  localparam logic [2:0] ST_RUN3 = 3'd3;
  localparam logic [2:0] ST_TAIL = 3'd4;

  // Symbol emitted while the generator sits in a given state
  function automatic logic [1:0] state_sym(input logic [2:0] st);
    logic [1:0] sym;
    case (st)
      ST_HEAD: sym = SYM_HEAD;
      ST_RUN2: sym = SYM_MID;
      ST_RUN3: sym = SYM_END;
      default: sym = SYM_IDLE;
    endcase
    return sym;
  endfunction

  // States whose symbol is part of the frame proper (terminator excluded)
  function automatic logic is_frame_state(input logic [2:0] st);
    return (st == ST_HEAD) || (st == ST_RUN2) || (st == ST_RUN3);
  endfunction

endpackage

// File: rtl/seq_len_counter.sv
// ---------------------------------------------------------------------------
// seq_len_counter
// Loadable CNT_W-bit down-counter used to time the 10 and 11 runs.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-high reset (count -> 0)
//   load     in   load load_val this cycle (priority over en)
//   load_val in   value to load
//   en       in   decrement this cycle
//   zero     out  count is zero
// ---------------------------------------------------------------------------
module seq_len_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // The FSM never decrements at zero, so no wrap guard is needed here.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/counting_seq_gen.sv
// ---------------------------------------------------------------------------
// counting_seq_gen
// Frame source for the 2-bit symbol sequence detector. On an accepted start
// it emits 01, len2 x 10, len3 x 11 and a single 00 terminator on num.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-high reset, back to IDLE immediately
//   start  in   frame request, honoured only while ready=1
//   len2   in   number of 10 symbols (0 behaves as 1), sampled at accept
//   len3   in   number of 11 symbols (0 behaves as 1), sampled at accept
//   hold   in   stall: freezes state, counter and num for the cycle
//   ready  out  idle and able to accept start
//   num    out  registered symbol stream
//   valid  out  num is a frame symbol presented after a non-held edge
//   done   out  one-cycle pulse with the 00 terminator
// ---------------------------------------------------------------------------
module counting_seq_gen
  import counting_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len2,
  input  logic [CNT_W-1:0] len3,
  input  logic             hold,
  output logic             ready,
  output logic [1:0]       num,
  output logic             valid,
  output logic             done
);

  // A zero length still yields one symbol, so the counter reload is len-1
  // with zero clamped to zero.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : (len - {{(CNT_W-1){1'b0}}, 1'b1});
  endfunction

  logic [2:0]       state_q, state_d;
  logic [1:0]       num_q, num_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] len3_q, len3_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_en;
  logic             cnt_zero;

  seq_len_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    valid_d      = 1'b0;
    done_d       = 1'b0;
    ready_d      = 1'b0;
    len3_d       = len3_q;
    cnt_load     = 1'b0;
    cnt_load_val = len_m1(len2);
    cnt_en       = 1'b0;

    // Under hold everything freezes and valid/done/ready drop to 0.
    if (!hold) begin
      case (state_q)
        ST_IDLE: begin
          if (start && ready_q) begin
            state_d  = ST_HEAD;
            cnt_load = 1'b1;
            len3_d   = len_m1(len3);
          end
        end
        ST_HEAD: state_d = ST_RUN2;
        ST_RUN2: begin
          if (cnt_zero) begin
            state_d      = ST_RUN3;
            cnt_load     = 1'b1;
            cnt_load_val = len3_q;
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_RUN3: begin
          if (cnt_zero) begin
            state_d = ST_TAIL;
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_TAIL: begin
          // done_q=0 here means the pulse was suppressed by a hold; stay one
          // more cycle so the terminator is presented again with done.
          if (done_q) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      num_d   = state_sym(state_d);
      valid_d = is_frame_state(state_d);
      done_d  = (state_d == ST_TAIL);
      ready_d = (state_d == ST_IDLE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      num_q   <= SYM_IDLE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      len3_q  <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      len3_q  <= len3_d;
    end
  end

  assign ready = ready_q;
  assign num   = num_q;
  assign valid = valid_q;
  assign done  = done_q;

endmodule

// File: tb/tb_counting_seq_gen.sv
module tb_counting_seq_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] len2;
  logic [3:0] len3;
  logic       hold;
  logic       ready;
  logic [1:0] num;
  logic       valid;
  logic       done;

  int n_pass  = 0;
  int n_total = 0;

  counting_seq_gen #(.CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .len2  (len2),
    .len3  (len3),
    .hold  (hold),
    .ready (ready),
    .num   (num),
    .valid (valid),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame vector: lengths, hold window (hold driven on edges hs..hs+hl-1,
  // counted in output cycles after the accepting edge) and expected counts.
  typedef struct {
    int l2, l3, hs, hl;
    int e01, e10, e11, estall, edcnt, edone;
  } vec_t;

  vec_t vecs[7];

  int exp_t1[8];
  int exp_bb[12];

  initial begin
    int n01, n10, n11, stall, dcnt, dat, rdy_at, bad, first, cyc;

    vecs[0] = '{l2:2,  l3:3,  hs:0, hl:0, e01:1, e10:2,  e11:3,  estall:0, edcnt:1, edone:7};
    vecs[1] = '{l2:0,  l3:0,  hs:0, hl:0, e01:1, e10:1,  e11:1,  estall:0, edcnt:1, edone:4};
    vecs[2] = '{l2:15, l3:15, hs:0, hl:0, e01:1, e10:15, e11:15, estall:0, edcnt:1, edone:32};
    vecs[3] = '{l2:2,  l3:3,  hs:4, hl:3, e01:1, e10:2,  e11:3,  estall:3, edcnt:1, edone:10};
    vecs[4] = '{l2:1,  l3:4,  hs:2, hl:2, e01:1, e10:1,  e11:4,  estall:2, edcnt:1, edone:9};
    vecs[5] = '{l2:3,  l3:1,  hs:1, hl:1, e01:1, e10:3,  e11:1,  estall:1, edcnt:1, edone:7};
    vecs[6] = '{l2:2,  l3:1,  hs:5, hl:1, e01:1, e10:2,  e11:1,  estall:0, edcnt:2, edone:7};

    exp_t1 = '{0, 1, 2, 2, 3, 3, 3, 0};
    exp_bb = '{0, 1, 2, 3, 0, 0, 1, 2, 3, 0, 0, 1};

    reset = 1'b1; start = 1'b0; hold = 1'b0; len2 = '0; len3 = '0;
    #12;
    check("rst_num",   num,   0);
    check("rst_valid", valid, 0);
    check("rst_done",  done,  0);
    check("rst_ready", ready, 1);
    reset = 1'b0;
    tick();

    // Exact frame for len2=2, len3=3
    len2 = 4'd2; len3 = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("t1_num_c%0d", c), num, exp_t1[c]);
      check($sformatf("t1_done_c%0d", c), done, (c == 7) ? 1 : 0);
      tick();
    end
    check("t1_ready_c8", ready, 1);
    check("t1_num_c8", num, 0);

    // Table-driven frames
    for (int v = 0; v < 7; v++) begin
      len2 = 4'(vecs[v].l2); len3 = 4'(vecs[v].l3); start = 1'b1; hold = 1'b0;
      tick();
      start = 1'b0;
      // Changing lengths mid-frame must not affect the latched frame
      len2 = 4'(vecs[v].l2 + 5); len3 = 4'(vecs[v].l3 + 7);
      n01 = 0; n10 = 0; n11 = 0; stall = 0; dcnt = 0; dat = 0;
      rdy_at = 0; bad = 0; first = -1; cyc = 1;
      while (rdy_at == 0 && cyc < 100) begin
        if (cyc == 1) first = num;
        if (ready) begin
          rdy_at = cyc;
        end else begin
          if (valid) begin
            case (num)
              2'b01: n01++;
              2'b10: n10++;
              2'b11: n11++;
              default: bad++;
            endcase
          end else if (num != 2'b00) begin
            stall++;
          end
          if (done) begin
            dcnt++;
            dat = cyc;
            if (valid || num != 2'b00) bad++;
          end
          hold = (cyc >= vecs[v].hs) && (cyc < vecs[v].hs + vecs[v].hl);
          tick();
          cyc++;
        end
      end
      hold = 1'b0;
      check($sformatf("v%0d_first", v), first, 1);
      check($sformatf("v%0d_n01", v),   n01,   vecs[v].e01);
      check($sformatf("v%0d_n10", v),   n10,   vecs[v].e10);
      check($sformatf("v%0d_n11", v),   n11,   vecs[v].e11);
      check($sformatf("v%0d_stall", v), stall, vecs[v].estall);
      check($sformatf("v%0d_dcnt", v),  dcnt,  vecs[v].edcnt);
      check($sformatf("v%0d_done", v),  dat,   vecs[v].edone);
      check($sformatf("v%0d_ready", v), rdy_at, vecs[v].edone + 1);
      check($sformatf("v%0d_bad", v),   bad,   0);
    end

    // Back-to-back frames with start held high
    len2 = 4'd1; len3 = 4'd1; start = 1'b1;
    tick();
    for (int c = 1; c <= 11; c++) begin
      check($sformatf("bb_num_c%0d", c), num, exp_bb[c]);
      check($sformatf("bb_done_c%0d", c), done, (c == 4 || c == 9) ? 1 : 0);
      tick();
    end
    start = 1'b0;
    cyc = 0;
    while (!ready && cyc < 20) begin
      tick();
      cyc++;
    end
    check("bb_idle_ready", ready, 1);

    // Asynchronous reset in the middle of the 10 run
    len2 = 4'd5; len3 = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_num_run2", num, 2);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_num",   num,   0);
    check("mid_rst_ready", ready, 1);
    check("mid_rst_valid", valid, 0);
    #1;
    reset = 1'b0;
    len2 = 4'd1; len3 = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("post_rst_head", num, 1);
    cyc = 1;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    check("post_rst_done_cyc", cyc, 4);
    tick();

    // Hold in IDLE blocks start
    hold = 1'b1;
    tick();
    check("hidle_ready", ready, 0);
    start = 1'b1;
    tick();
    tick();
    check("hidle_num",   num,   0);
    check("hidle_valid", valid, 0);
    hold = 1'b0; start = 1'b0;
    tick();
    check("hidle_release_ready", ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
